// File: rtl/concurrent_assertion_pkg.sv
// concurrent_assertion_pkg
//   Shared definitions for the request/grant responder and its protocol
//   checker: the pending-attempt slot type, the failure message format and
//   the default failure-counter width.
`timescale 1ns/1ps
package concurrent_assertion_pkg;

    // Default width of the saturating failure counter.
    localparam int unsigned CNT_W_DEFAULT = 16;

    // Message printed by the concurrent assertion on a protocol failure;
    // the single argument is the simulation time in ns.
    localparam string FAIL_MSG_FMT = "@%0dns Assertion Failed";

    // Pending-attempt slots of the shadow checker.
    //   s1 : attempt waiting for its grant cycle
    //   s2 : attempt waiting for its idle cycle
    typedef struct packed {
        logic s1;
        logic s2;
    } slots_t;

endpackage

// File: rtl/req_gnt_checker.sv
// req_gnt_checker
//   Synthesizable shadow checker plus equivalent concurrent assertions for
//   the rule: a request at edge n must be followed by a grant-only cycle at
//   n+1 and a fully idle cycle at n+2.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset; clears slots and counter
//   req   - request as seen by the responder
//   gnt   - registered grant produced by the responder
`timescale 1ns/1ps
module req_gnt_checker
    import concurrent_assertion_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic gnt
);

    slots_t             r_slots;
    logic [CNT_W-1:0]   r_fail_cnt;

    // Boolean layer: the two cycle shapes an attempt must see.
    logic w_grant_cycle;
    logic w_idle_cycle;
    assign w_grant_cycle = !req &&  gnt;
    assign w_idle_cycle  = !req && !gnt;

    logic             w_fail_grant;
    logic             w_fail_idle;
    logic [1:0]       w_inc;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_next;

    always_comb begin
        w_fail_grant = r_slots.s1 && !w_grant_cycle;
        w_fail_idle  = r_slots.s2 && !w_idle_cycle;
        w_inc        = {1'b0, w_fail_grant} + {1'b0, w_fail_idle};
        w_sum        = {1'b0, r_fail_cnt} + (CNT_W+1)'(w_inc);
        // Carry out of the counter width means saturate.
        w_cnt_next   = w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_slots    <= '0;
            r_fail_cnt <= '0;
        end else begin
            // An attempt reaches the idle slot only if its grant cycle passed.
            r_slots.s2 <= r_slots.s1 && !w_fail_grant;
            r_slots.s1 <= req;
            r_fail_cnt <= w_cnt_next;
        end
    end

    // Property layer. The two-cycle consequent
    //   req |=> (~req & gnt) ##1 (~req & ~gnt)
    // is written as one property per cycle: the idle check is armed only by
    // an attempt whose grant cycle has just passed. Gating $past with reset
    // keeps attempts from reset-time edges out, matching disable iff.
    property p_grant;
        @(posedge clk) disable iff (!reset)
            req |=> w_grant_cycle;
    endproperty

    property p_idle;
        @(posedge clk) disable iff (!reset)
            ($past(req && reset) && w_grant_cycle) |=> w_idle_cycle;
    endproperty

    // Directive layer.
    a_grant: assert property (p_grant) else $display(FAIL_MSG_FMT, $time);
    a_idle:  assert property (p_idle)  else $display(FAIL_MSG_FMT, $time);

endmodule

// File: rtl/concurrent_assertion.sv
// concurrent_assertion
//   Registered request-to-grant responder: gnt follows req with exactly one
//   cycle of latency. A req_gnt_checker instance monitors the handshake.
// Ports:
//   clk   - rising-edge clock
//   req   - request, sampled on posedge clk
//   reset - asynchronous active-low reset; forces gnt low immediately
//   gnt   - registered grant
`timescale 1ns/1ps
module concurrent_assertion
    import concurrent_assertion_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic req,
    input  logic reset,
    output logic gnt
);

    logic r_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gnt <= 1'b0;
        end else begin
            r_gnt <= req;
        end
    end

    assign gnt = r_gnt;

    req_gnt_checker #(
        .CNT_W (CNT_W)
    ) u_chk (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .gnt   (r_gnt)
    );

endmodule

// File: tb/tb_concurrent_assertion.sv
// tb_concurrent_assertion
//   Directed bench for concurrent_assertion. Two instances share stimulus:
//   one with the default counter width and one with CNT_W = 2 to exercise
//   saturation. A history-based model derives the expected grant and
//   failure count from the handshake rule; literal checks pin key points.
`timescale 1ns/1ps
module tb_concurrent_assertion;

    logic clk;
    logic req;
    logic reset;
    logic gnt16;
    logic gnt2;

    int checks = 0;
    int errors = 0;

    concurrent_assertion u_dut16 (
        .clk   (clk),
        .req   (req),
        .reset (reset),
        .gnt   (gnt16)
    );

    concurrent_assertion #(
        .CNT_W (2)
    ) u_dut2 (
        .clk   (clk),
        .req   (req),
        .reset (reset),
        .gnt   (gnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Model: per-edge history of (req, grant seen at that edge) since the
    // last reset-released edge. Failures are counted directly from the rule.
    // ------------------------------------------------------------------
    bit req_h[$];
    bit gnt_h[$];
    bit m_gnt = 1'b0;
    int m_cnt = 0;

    // Inputs change 1 ns after a falling edge, so at the falling edge they
    // still hold what the preceding rising edge sampled.
    always @(negedge clk) begin
        int n;
        int f;
        if (!reset) begin
            req_h = {};
            gnt_h = {};
            m_gnt = 1'b0;
            m_cnt = 0;
        end else begin
            req_h.push_back(req);
            gnt_h.push_back(m_gnt);
            n = req_h.size() - 1;
            f = 0;
            if (n >= 1 && req_h[n-1] && (req_h[n] || !gnt_h[n]))
                f++;
            if (n >= 2 && req_h[n-2] && !req_h[n-1] && gnt_h[n-1]
                && (req_h[n] || gnt_h[n]))
                f++;
            m_gnt = req;
            m_cnt += f;
        end
        check("gnt16", 32'(gnt16), 32'(m_gnt));
        check("gnt2", 32'(gnt2), 32'(m_gnt));
        check("fail_cnt16", 32'(u_dut16.u_chk.r_fail_cnt), 32'(m_cnt));
        check("fail_cnt2", 32'(u_dut2.u_chk.r_fail_cnt), (m_cnt > 3) ? 32'd3 : 32'(m_cnt));
    end

    // One clock edge with the given request level; returns 1 ns after the
    // following falling edge.
    task automatic cyc(input logic q);
        req = q;
        @(negedge clk);
        #1;
    endtask

    initial begin
        req   = 1'b1;
        reset = 1'b0;

        // Reset held with req high.
        #21;
        check("rst_gnt", 32'(gnt16), 32'd0);
        check("rst_cnt", 32'(u_dut16.u_chk.r_fail_cnt), 32'd0);
        reset = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        check("post_rst_cnt", 32'(u_dut16.u_chk.r_fail_cnt), 32'd0);

        // Single pulse.
        cyc(1'b1);
        check("pulse_gnt_hi", 32'(gnt16), 32'd1);
        cyc(1'b0);
        check("pulse_gnt_lo", 32'(gnt16), 32'd0);
        cyc(1'b0);
        cyc(1'b0);
        check("pulse_cnt", 32'(u_dut16.u_chk.r_fail_cnt), 32'd0);

        // Held request for 5 edges: 4 failures.
        for (int i = 0; i < 5; i++) cyc(1'b1);
        check("held_gnt", 32'(gnt16), 32'd1);
        cyc(1'b0);
        check("held_gnt_tail", 32'(gnt16), 32'd0);
        cyc(1'b0);
        cyc(1'b0);
        check("held_cnt16", 32'(u_dut16.u_chk.r_fail_cnt), 32'd4);
        check("held_cnt2", 32'(u_dut2.u_chk.r_fail_cnt), 32'd3);

        // Back-to-back pulses one idle edge apart: one more failure.
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        check("b2b_cnt16", 32'(u_dut16.u_chk.r_fail_cnt), 32'd5);

        // Reset in the middle of an attempt.
        cyc(1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_gnt_async", 32'(gnt16), 32'd0);
        check("mid_rst_cnt_async", 32'(u_dut16.u_chk.r_fail_cnt), 32'd0);
        cyc(1'b1);
        cyc(1'b0);
        cyc(1'b1);
        reset = 1'b1;
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        check("mid_rst_cnt", 32'(u_dut16.u_chk.r_fail_cnt), 32'd0);

        // Saturation: 5 failures.
        for (int i = 0; i < 6; i++) cyc(1'b1);
        cyc(1'b0);
        cyc(1'b0);
        cyc(1'b0);
        check("sat_cnt16", 32'(u_dut16.u_chk.r_fail_cnt), 32'd5);
        check("sat_cnt2", 32'(u_dut2.u_chk.r_fail_cnt), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/concurrent_assertion.md
# concurrent_assertion

Registered request-to-grant responder with a built-in request/grant protocol checker. Each request sampled on a clock edge is answered by a grant on the following edge. A synthesizable shadow checker and an equivalent SVA property flag any request that is not followed by exactly one grant cycle and one idle cycle. The block is a leaf in the handshake path and doubles as the team's reference for layered concurrent assertions: boolean, sequence, property and directive.

## Interface
- `CNT_W`, default 16: width of the internal saturating failure counter.
- `clk`, input, 1: rising-edge clock, the only clock.
- `reset`, input, 1: asynchronous, active-low reset; the block is held in reset while `reset` = 0.
- `req`, input, 1: request, sampled at each `posedge clk`.
- `gnt`, output, 1: registered grant.
- Port order is fixed: `clk`, `req`, `reset`, `gnt`. Connections are positional.

## Operation
- Datapath: at each `posedge clk`, `gnt` takes the value `req` had at that edge, giving one cycle of latency.
- Reset: `gnt` goes to 0 immediately when `reset` falls, with no clock required. It stays 0 while reset is held.
- Protocol rule:
  - If `req` = 1 at edge n, edge n+1 must see `req` = 0 and `gnt` = 1.
  - Edge n+2 must then see `req` = 0 and `gnt` = 0.
  - Any other pattern is a failure.
- SVA form: `req |=> (~req & gnt) ##1 (~req & ~gnt)`, clocked on `posedge clk`, `disable iff` reset is asserted.
  - On failure the else-action prints `@<time>ns Assertion Failed` via `$display`.
- Shadow checker, synthesizable: two pending-attempt slots, `s1` (expects the grant cycle) and `s2` (expects the idle cycle). Each edge:
  - If `s2` is set and (`req` or `gnt`) is 1, record a failure.
  - If `s1` is set and (`req` = 1 or `gnt` = 0), record a failure. Otherwise move the attempt into `s2`.
  - If `req` = 1, load a new attempt into `s1`.
  - Each edge records at most one failure per slot.
- Failure counter `fail_cnt` (internal, `CNT_W` bits): increments once per recorded failure and saturates at its maximum value.
- Asserting reset clears both slots and the counter asynchronously and abandons any in-flight attempt; no failure is reported for it.

## Timing
- Reset values: `gnt` = 0, `s1` = `s2` = 0, `fail_cnt` = 0.
- Grant latency is exactly one cycle, with no combinational path from `req` to `gnt`.
- A one-cycle `req` pulse followed by two idle cycles passes: `gnt` is high for exactly the cycle after the pulse.
- `req` held for k ≥ 2 cycles:
  - Fails on each of the k−1 edges after the first high edge.
  - The attempt started on the last high edge passes.
- Two `req` pulses separated by one idle edge:
  - The first attempt fails at the second pulse, because `req` is high during its idle cycle.
  - The second attempt is evaluated independently.
- When reset is released, attempts start from the first edge where reset is deasserted.

## Structure
- Package `concurrent_assertion_pkg` holds:
  - the checker slot type;
  - the failure message format string;
  - the default `CNT_W` constant.
- Sub-module `req_gnt_checker`:
  - inputs `clk`, `reset`, `req`, `gnt`;
  - contains the shadow slots, the counter and the SVA directive;
  - is instantiated inside `concurrent_assertion`. The top level contains only the grant flop.

## Test plan
- Reset: drive `reset` = 0 with `req` = 1 for 20 ns, then release → `gnt` stays 0 throughout reset, no failures, `fail_cnt` = 0.
- Single pulse: `req` = 1 for one cycle at edge n → `gnt` = 1 only at edge n+1, no assertion message, `fail_cnt` = 0.
- Held request: `req` = 1 for 5 cycles at edges n..n+4 → `gnt` is high at edges n+1..n+5, with 4 failures at edges n+1..n+4. Expect 4 `Assertion Failed` lines and `fail_cnt` = 4.
- Back-to-back pulses: `req` = 1 at edges n and n+2 → 1 failure at edge n+2; the second attempt passes.
- Mid-attempt reset: pulse `req` at edge n, assert `reset` before edge n+1, release after edge n+3 → `gnt` is forced 0 asynchronously, no failure, `fail_cnt` = 0.
- Saturation: use `CNT_W` = 2 with 5 failures → `fail_cnt` = 3.
